// File: rtl/uart_tx_byte_sched.sv
// Per-byte round-robin scheduler: RAM frame bursts and echo bytes into the UART TX FIFO.
// Latency: frame byte 4 cycles (IDLE, RD, LAT, PUSH_F); echo byte 2 cycles (IDLE, PUSH_E).
// Backpressure: fifo_wrfull stalls PUSH_F/PUSH_E; echo_ready is asserted only when a write occurs.
module uart_tx_byte_sched #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              echo_valid,
    input  logic [DATA_W-1:0] echo_data,
    output logic              echo_ready,
    input  logic              fifo_wrfull,
    output logic              fifo_wrreq,
    output logic [DATA_W-1:0] fifo_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        LAT    = 3'd2,
        PUSH_F = 3'd3,
        PUSH_E = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic [DATA_W-1:0]   hold;
    logic                last_grant;   // 1 = echo served last, 0 = frame served last
    logic                grant_f;
    logic                grant_e;
    logic                start_acc;
    logic                frame_pend;
    logic                frame_wr;

    // A start is only honoured between bursts; a busy start has no effect at all.
    assign start_acc  = start && !busy;
    assign frame_pend = busy && (remaining != '0);
    assign frame_wr   = (state_q == PUSH_F) && !fifo_wrfull;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, arbitration and all combinational outputs.
    always_comb begin
        state_d    = state_q;
        grant_f    = 1'b0;
        grant_e    = 1'b0;
        ram_rden   = 1'b0;
        ram_addr   = '0;
        fifo_wrreq = 1'b0;
        fifo_data  = '0;
        echo_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the source that did not win last time gets the byte slot.
                if (frame_pend && echo_valid) begin
                    if (last_grant) grant_f = 1'b1;
                    else            grant_e = 1'b1;
                end else if (frame_pend) begin
                    grant_f = 1'b1;
                end else if (echo_valid) begin
                    grant_e = 1'b1;
                end
                if (grant_f)      state_d = RD;
                else if (grant_e) state_d = PUSH_E;
            end
            RD: begin
                ram_rden = 1'b1;
                ram_addr = cur_addr;
                state_d  = LAT;
            end
            LAT: begin
                state_d = PUSH_F;
            end
            PUSH_F: begin
                fifo_data  = hold;
                fifo_wrreq = !fifo_wrfull;
                if (!fifo_wrfull) state_d = IDLE;
            end
            PUSH_E: begin
                fifo_data = echo_data;
                // A source that withdraws its byte loses the slot without a write.
                if (!echo_valid) begin
                    state_d = IDLE;
                end else begin
                    fifo_wrreq = !fifo_wrfull;
                    echo_ready = !fifo_wrfull;
                    if (!fifo_wrfull) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: address/count load on start, advance on each frame write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_acc) begin
                cur_addr  <= base_addr;
                remaining <= length;
                busy      <= (length != '0);
                done      <= (length == '0);
            end else if (frame_wr) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Capture RAM data one cycle after the read; it stays put while the FIFO is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (state_q == LAT) begin
            hold <= ram_q;
        end
    end

    // Remember which source won the last byte slot for the round-robin tie break.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_f) begin
            last_grant <= 1'b0;
        end else if (grant_e) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_byte_sched.sv
// Directed bench for uart_tx_byte_sched: bursts, wrap, FIFO stall, arbitration, zero length, reset.
// A negedge monitor logs FIFO writes, RAM reads and done pulses; steps compare the logs to hand values.
// The RAM model answers ram_rden one cycle later with mem[a] = a+1.
module tb_uart_tx_byte_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [7:0] ram_addr;
    logic       ram_rden;
    logic [7:0] ram_q;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       echo_ready;
    logic       fifo_wrfull;
    logic       fifo_wrreq;
    logic [7:0] fifo_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_dat [$];
    int         wr_cyc [$];
    logic       wr_echo [$];
    logic [7:0] rd_addr [$];
    int         done_cnt;
    int         done_cyc;
    logic       done_busy;
    int         er_bad;

    uart_tx_byte_sched #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .echo_ready (echo_ready),
        .fifo_wrfull(fifo_wrfull),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (fifo_wrreq) begin
            wr_dat.push_back(fifo_data);
            wr_cyc.push_back(cyc);
            wr_echo.push_back(echo_ready);
        end
        if (echo_ready && !fifo_wrreq) er_bad = er_bad + 1;
        if (ram_rden) rd_addr.push_back(ram_addr);
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert = n_assert + 1;
        assert (obs === exp_v) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_log();
        wr_dat.delete();
        wr_cyc.delete();
        wr_echo.delete();
        rd_addr.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        done_busy = 1'b0;
        er_bad    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(posedge clk);
        #1 start  = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    logic [7:0] exp_d [7];
    logic       exp_e [7];
    int         rel_cyc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        echo_valid = 1'b0; echo_data = 8'h55; fifo_wrfull = 1'b0; ram_q = '0;
        clear_log();

        // Reset values
        #12;
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_done",     32'(done),       32'd0);
        chk("rst_rden",     32'(ram_rden),   32'd0);
        chk("rst_addr",     32'(ram_addr),   32'd0);
        chk("rst_wrreq",    32'(fifo_wrreq), 32'd0);
        chk("rst_fdata",    32'(fifo_data),  32'd0);
        chk("rst_eready",   32'(echo_ready), 32'd0);
        do_reset();

        // Basic burst: base 0, len 4
        pulse_start(8'h00, 9'd4);
        chk("b_busy", 32'(busy), 32'd1);
        wait_done(1, "b_done_seen");
        chk("b_nwr", 32'(wr_dat.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_dat%0d", i), 32'(wr_dat[i]), 32'(i + 1));
            chk($sformatf("b_rd%0d", i), 32'(rd_addr[i]), 32'(i));
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("b_gap%0d", i), 32'(wr_cyc[i+1] - wr_cyc[i]), 32'd4);
        chk("b_done_cyc", 32'(done_cyc - wr_cyc[3]), 32'd1);
        chk("b_done_busy", 32'(done_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("b_done_once", 32'(done_cnt), 32'd1);

        // Address wrap: base FE, len 4
        clear_log();
        pulse_start(8'hFE, 9'd4);
        wait_done(1, "w_done_seen");
        repeat (10) @(posedge clk);
        #1;
        chk("w_nrd", 32'(rd_addr.size()), 32'd4);
        chk("w_rd0", 32'(rd_addr[0]), 32'hFE);
        chk("w_rd1", 32'(rd_addr[1]), 32'hFF);
        chk("w_rd2", 32'(rd_addr[2]), 32'h00);
        chk("w_rd3", 32'(rd_addr[3]), 32'h01);
        chk("w_dat1", 32'(wr_dat[1]), 32'h00);
        chk("w_nwr", 32'(wr_dat.size()), 32'd4);
        chk("w_done_once", 32'(done_cnt), 32'd1);

        // FIFO full stall in PUSH_F: base 0x20, len 2
        clear_log();
        fifo_wrfull = 1'b1;
        pulse_start(8'h20, 9'd2);
        repeat (13) @(posedge clk);
        #1;
        chk("f_nwr_stall", 32'(wr_dat.size()), 32'd0);
        chk("f_nrd_stall", 32'(rd_addr.size()), 32'd1);
        chk("f_rd0", 32'(rd_addr[0]), 32'h20);
        chk("f_fdata_a", 32'(fifo_data), 32'h21);
        repeat (5) @(posedge clk);
        #1;
        chk("f_fdata_b", 32'(fifo_data), 32'h21);
        chk("f_nrd_b", 32'(rd_addr.size()), 32'd1);
        fifo_wrfull = 1'b0;
        rel_cyc = cyc;
        wait_done(1, "f_done_seen");
        chk("f_nwr", 32'(wr_dat.size()), 32'd2);
        chk("f_wr_first", 32'(wr_cyc[0]), 32'(rel_cyc));
        chk("f_dat0", 32'(wr_dat[0]), 32'h21);
        chk("f_dat1", 32'(wr_dat[1]), 32'h22);
        chk("f_rd1", 32'(rd_addr[1]), 32'h21);

        // Zero length: done next cycle, no reads, busy stays low
        clear_log();
        pulse_start(8'h30, 9'd0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("z_done_pulse", 32'(done), 32'd0);
        chk("z_busy2", 32'(busy), 32'd0);
        chk("z_nrd", 32'(rd_addr.size()), 32'd0);

        // Start while busy is ignored
        clear_log();
        pulse_start(8'h60, 9'd2);
        @(posedge clk);
        #1;
        pulse_start(8'h80, 9'd5);
        wait_done(1, "sb_done_seen");
        repeat (20) @(posedge clk);
        #1;
        chk("sb_nwr", 32'(wr_dat.size()), 32'd2);
        chk("sb_rd0", 32'(rd_addr[0]), 32'h60);
        chk("sb_rd1", 32'(rd_addr[1]), 32'h61);
        chk("sb_done_once", 32'(done_cnt), 32'd1);
        chk("sb_busy", 32'(busy), 32'd0);

        // Arbitration: echo 0x55 held, frame len 3 from 0x40
        do_reset();
        pulse_start(8'h40, 9'd3);
        echo_valid = 1'b1;
        wait_done(1, "a_done_seen");
        repeat (6) @(posedge clk);
        #1 echo_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_d = '{8'h41, 8'h55, 8'h42, 8'h55, 8'h43, 8'h55, 8'h55};
        exp_e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        chk("a_nwr_min", 32'(wr_dat.size() >= 7), 32'd1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("a_dat%0d", i), 32'(wr_dat[i]), 32'(exp_d[i]));
            chk($sformatf("a_src%0d", i), 32'(wr_echo[i]), 32'(exp_e[i]));
        end
        chk("a_eready_only_wr", 32'(er_bad), 32'd0);
        chk("a_done_once", 32'(done_cnt), 32'd1);

        // Reset mid-burst during PUSH_F of the second byte
        do_reset();
        pulse_start(8'h00, 9'd5);
        begin
            int n = 0;
            while (wr_dat.size() < 1 && n < 50) begin
                @(posedge clk);
                n++;
            end
        end
        #1 fifo_wrfull = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("r_nrd_pre", 32'(rd_addr.size()), 32'd2);
        chk("r_wrreq_pre", 32'(fifo_wrreq), 32'd0);
        #3;
        rst = 1'b1;
        fifo_wrfull = 1'b0;
        #1;
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_done", 32'(done), 32'd0);
        chk("r_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("r_rden", 32'(ram_rden), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("r_no_done", 32'(done_cnt), 32'd0);
        chk("r_nwr", 32'(wr_dat.size()), 32'd1);
        clear_log();
        pulse_start(8'h10, 9'd1);
        wait_done(1, "r2_done_seen");
        chk("r2_rd0", 32'(rd_addr[0]), 32'h10);
        chk("r2_dat0", 32'(wr_dat[0]), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_byte_sched.md
Name: uart_tx_byte_sched

Overview:
- Per-byte scheduler that feeds the UART transmit FIFO from two sources: the frame engine and the echo channel.
- The frame engine reads a burst of bytes from the single-port data RAM. A burst is defined by a base address and a length and is started by a pulse.
- The echo channel passes single bytes through a valid/ready handshake, for example bytes echoed back from the receiver.
- The block sits between the RAM, the echo source and the TX FIFO write port, and round-robin arbitrates per byte between the two sources.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, byte width of RAM data, echo data and FIFO data
LEN_W, 9, width of burst length (max 2^LEN_W-1 bytes)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse, request a frame burst
base_addr  input  ADDR_W  first RAM address of burst, sampled on accepted start
length  input  LEN_W  byte count of burst, sampled on accepted start
busy  output  1  frame burst in progress
done  output  1  one-cycle pulse, frame burst finished
ram_addr  output  ADDR_W  RAM read address
ram_rden  output  1  RAM read enable
ram_q  input  DATA_W  RAM read data, valid one cycle after ram_rden
echo_valid  input  1  echo byte available
echo_data  input  DATA_W  echo byte; held stable while echo_valid=1
echo_ready  output  1  echo byte accepted this cycle
fifo_wrfull  input  1  TX FIFO full
fifo_wrreq  output  1  TX FIFO write strobe
fifo_data  output  DATA_W  TX FIFO write data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; done=0.
  - ram_addr=0, ram_rden=0.
  - fifo_data=0, hold=0.
  - remaining=0; last_grant=1 (echo), so the frame wins the first tie.
  - Combinational outputs resolve to 0 in IDLE.
  - Reset mid-burst abandons the burst; no done pulse follows.
- Start acceptance:
  - start is accepted only when busy=0.
  - On acceptance: cur_addr<=base_addr, remaining<=length.
  - If length!=0: busy<=1 next cycle.
  - If length==0: done=1 in the next cycle, busy stays 0, no RAM reads.
  - start while busy=1 is ignored, with no side effects.
- States: IDLE, RD, LAT, PUSH_F, PUSH_E.
- IDLE arbitration:
  - frame_pend = busy and remaining!=0.
  - If frame_pend and echo_valid: grant the source opposite last_grant.
  - Otherwise grant whichever source is pending.
  - Frame grant -> RD, last_grant<=0. Echo grant -> PUSH_E, last_grant<=1.
  - Nothing pending: stay in IDLE.
- RD: ram_rden=1, ram_addr=cur_addr -> LAT.
- LAT: ram_rden=0; at end of cycle hold<=ram_q -> PUSH_F.
- PUSH_F:
  - fifo_data=hold; fifo_wrreq = !fifo_wrfull (combinational).
  - On a write: cur_addr<=cur_addr+1 (wraps to 0 after 2^ADDR_W-1), remaining<=remaining-1, then -> IDLE.
  - If that write takes remaining to 0: busy<=0 and done<=1 in the same next cycle.
  - While fifo_wrfull=1: hold state; fifo_data stable, cur_addr/remaining unchanged, no RAM read.
- PUSH_E:
  - fifo_data=echo_data (mux, no register stage).
  - fifo_wrreq = echo_ready = !fifo_wrfull; on a write -> IDLE.
  - If echo_valid drops while waiting (protocol violation): return to IDLE with no write.
- echo_ready is 0 in every state except PUSH_E.
- Exactly one fifo_wrreq cycle per byte.
- Minimum spacing between bytes:
  - frame byte: 4 cycles (IDLE, RD, LAT, PUSH_F);
  - echo byte: 2 cycles (IDLE, PUSH_E).
- done is a registered one-cycle pulse. busy falls in the same cycle done rises.

Test Plan:
- Basic burst:
  - Stimulus: RAM[a]=a+1; start with base 0x00, len 4; wrfull=0; no echo.
  - Response: ram_addr reads 00..03; fifo_wrreq pulses 4 cycles apart with data 01,02,03,04; done pulse 1 cycle after the 4th write; busy=0 in that cycle.
- Address wrap:
  - Stimulus: base 0xFE, len 4.
  - Response: ram_addr sequence FE,FF,00,01; 4 writes; done once.
- FIFO full:
  - Stimulus: wrfull=1 for 10 cycles while in PUSH_F.
  - Response: fifo_wrreq=0 throughout, fifo_data stable, no further ram_rden; the write happens in the first cycle with wrfull=0; burst resumes at the next address.
- Arbitration:
  - Stimulus: echo_valid=1 with echo_data=0x55 held, start len 3.
  - Response: FIFO write order F0,E,F1,E,F2,E,E...; echo_ready is high only on echo writes.
- Zero length and start while busy:
  - Stimulus: start with len 0; separately, a second start while busy.
  - Response: len 0 gives a done pulse next cycle, ram_rden never asserted, busy stays 0. The second start is ignored and the burst count is unchanged.
- Reset mid-burst:
  - Stimulus: rst=1 during PUSH_F of byte 2 of len 5.
  - Response: busy/done/fifo_wrreq/ram_rden are 0 immediately and no done pulse follows. After release, a new start with base 0x10 reads from 0x10.
